// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART ROM command stage.
package uart_cmd_pkg;

    // Parser / reply sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        WAIT_CR = 3'd2,
        ROM     = 3'd3,
        ERR     = 3'd4,
        TX      = 3'd5
    } state_e;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_QM   = 8'h3F;
    localparam logic [7:0] ASCII_R_UP = 8'h52;
    localparam logic [7:0] ASCII_R_LO = 8'h72;
    localparam logic [7:0] ASCII_1    = 8'h31;
    localparam logic [7:0] ASCII_2    = 8'h32;
    localparam logic [7:0] ASCII_3    = 8'h33;
    localparam logic [7:0] ASCII_4    = 8'h34;

    // Cycles between transmitter kicks: whole-cycle bit period times frame length
    function automatic int unsigned tx_gap(input int unsigned clock_freq_hz,
                                           input int unsigned baud_rate,
                                           input int unsigned bit_width);
        return (clock_freq_hz / baud_rate) * bit_width;
    endfunction

endpackage

// File: rtl/hex_ascii_codec.sv
// Combinational hex <-> ASCII conversion (uppercase on encode, either case on decode).
module hex_ascii_codec (
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o,
    input  logic [7:0] ascii_i,
    output logic [3:0] nibble_o,
    output logic       is_hex_o
);

    // Nibble to uppercase ASCII hex digit
    always_comb begin
        if (nibble_i < 4'd10) begin
            ascii_o = 8'h30 + {4'h0, nibble_i};
        end else begin
            ascii_o = 8'h37 + {4'h0, nibble_i};
        end
    end

    // ASCII hex digit to nibble; is_hex_o flags a legal digit
    always_comb begin
        nibble_o = 4'h0;
        is_hex_o = 1'b0;
        if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
            nibble_o = ascii_i[3:0];
            is_hex_o = 1'b1;
        end else if ((ascii_i >= 8'h41 && ascii_i <= 8'h46) ||
                     (ascii_i >= 8'h61 && ascii_i <= 8'h66)) begin
            nibble_o = ascii_i[3:0] + 4'd9;
            is_hex_o = 1'b1;
        end
    end

endmodule

// File: rtl/uart_rom_cmd.sv
// UART command stage: parses "R<3 hex>CR", reads the ROM and replies in ASCII
// hex; '1'..'4' toggle the LEDs. Replies are paced at a fixed gap because the
// transmitter has no ready handshake.
module uart_rom_cmd
    import uart_cmd_pkg::*;
#(
    parameter int unsigned BIT_WIDTH     = 11,
    parameter int unsigned BAUD_RATE     = 230400,
    parameter int unsigned CLOCK_FREQ_HZ = 100000000,
    parameter int unsigned ADDR_W        = 12,
    parameter int unsigned DATA_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_send,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic [3:0]        led,
    output logic              busy,
    output logic [2:0]        state_dbg_o
);

    // Handshake: rx_valid is a one-cycle strobe with rx_data valid in that
    // cycle and no back-pressure; tx_send is a one-cycle strobe with tx_data
    // held until the next strobe, spaced TX_GAP cycles since the UART has no ready.

    localparam int unsigned TX_GAP = tx_gap(CLOCK_FREQ_HZ, BAUD_RATE, BIT_WIDTH);
    localparam int unsigned GAP_W  = $clog2(TX_GAP + 1);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [3:0]        led_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic [2:0]        idx_q;
    logic [2:0]        len_q;
    logic [GAP_W-1:0]  gap_q;
    logic              tx_send_q;
    logic [7:0]        tx_data_q;

    logic [3:0]        tx_nib;
    logic [7:0]        tx_hex;
    logic [3:0]        rx_nib;
    logic              rx_is_hex;
    logic [7:0]        cur_byte;
    logic              gap_zero;
    logic              reply_done;

    hex_ascii_codec u_codec (
        .nibble_i (tx_nib),
        .ascii_o  (tx_hex),
        .ascii_i  (rx_data),
        .nibble_o (rx_nib),
        .is_hex_o (rx_is_hex)
    );

    assign gap_zero   = (gap_q == '0);
    assign reply_done = (idx_q == len_q);

    // Select the reply byte at the current index (data nibbles MS first, then CR LF)
    always_comb begin
        tx_nib   = 4'h0;
        cur_byte = ASCII_LF;
        case (idx_q)
            3'd0: tx_nib = data_q[15:12];
            3'd1: tx_nib = data_q[11:8];
            3'd2: tx_nib = data_q[7:4];
            3'd3: tx_nib = data_q[3:0];
            default: tx_nib = 4'h0;
        endcase
        if (err_q) begin
            case (idx_q)
                3'd0:    cur_byte = ASCII_QM;
                3'd1:    cur_byte = ASCII_CR;
                default: cur_byte = ASCII_LF;
            endcase
        end else begin
            if (idx_q < 3'd4) begin
                cur_byte = tx_hex;
            end else if (idx_q == 3'd4) begin
                cur_byte = ASCII_CR;
            end else begin
                cur_byte = ASCII_LF;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: parse in IDLE/ADDR/WAIT_CR, sequence the reply in TX
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_valid && (rx_data == ASCII_R_UP || rx_data == ASCII_R_LO)) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (rx_valid) begin
                    if (!rx_is_hex) begin
                        state_d = ERR;
                    end else if (cnt_q == 2'd2) begin
                        state_d = WAIT_CR;
                    end
                end
            end
            WAIT_CR: begin
                if (rx_valid) begin
                    state_d = (rx_data == ASCII_CR) ? ROM : ERR;
                end
            end
            ROM:     state_d = TX;
            ERR:     state_d = TX;
            TX: begin
                if (gap_zero && reply_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs derived from state
    always_comb begin
        busy        = (state_q == TX);
        state_dbg_o = state_q;
    end

    // Datapath: LEDs, address shift, reply load and paced transmit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 2'd0;
            rom_addr_q <= '0;
            led_q      <= 4'h0;
            data_q     <= '0;
            err_q      <= 1'b0;
            idx_q      <= 3'd0;
            len_q      <= 3'd0;
            gap_q      <= '0;
            tx_send_q  <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            tx_send_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            ASCII_1:    led_q[0] <= ~led_q[0];
                            ASCII_2:    led_q[1] <= ~led_q[1];
                            ASCII_3:    led_q[2] <= ~led_q[2];
                            ASCII_4:    led_q[3] <= ~led_q[3];
                            ASCII_R_UP,
                            ASCII_R_LO: cnt_q    <= 2'd0;
                            default:    ;
                        endcase
                    end
                end
                ADDR: begin
                    if (rx_valid && rx_is_hex) begin
                        rom_addr_q <= {rom_addr_q[ADDR_W-5:0], rx_nib};
                        cnt_q      <= cnt_q + 2'd1;
                    end
                end
                ROM: begin
                    data_q <= rom_dout;
                    err_q  <= 1'b0;
                    len_q  <= 3'd6;
                    idx_q  <= 3'd0;
                    gap_q  <= '0;
                end
                ERR: begin
                    err_q <= 1'b1;
                    len_q <= 3'd3;
                    idx_q <= 3'd0;
                    gap_q <= '0;
                end
                TX: begin
                    if (gap_zero) begin
                        if (!reply_done) begin
                            tx_send_q <= 1'b1;
                            tx_data_q <= cur_byte;
                            idx_q     <= idx_q + 3'd1;
                            gap_q     <= GAP_W'(TX_GAP - 1);
                        end
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_send  = tx_send_q;
    assign tx_data  = tx_data_q;
    assign rom_addr = rom_addr_q;
    assign led      = led_q;

endmodule

// File: tb/tb_uart_rom_cmd.sv
// Bench for uart_rom_cmd: directed commands, expected reply bytes queued by
// the driver and checked by an independent monitor on tx_send.
module tb_uart_rom_cmd;

  // 1_000_000 / 23_000 = 43 (integer), 43 * 11 = 473 cycles between sends
  localparam int CLK_HZ  = 1000000;
  localparam int BAUD    = 23000;
  localparam int BITS    = 11;
  localparam int EXP_GAP = 473;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic [11:0] rom_addr;
  logic [15:0] rom_dout;
  logic [3:0]  led;
  logic        busy;
  logic [2:0]  state_dbg;

  uart_rom_cmd #(
    .BIT_WIDTH     (BITS),
    .BAUD_RATE     (BAUD),
    .CLOCK_FREQ_HZ (CLK_HZ),
    .ADDR_W        (12),
    .DATA_W        (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_send     (tx_send),
    .tx_data     (tx_data),
    .rom_addr    (rom_addr),
    .rom_dout    (rom_dout),
    .led         (led),
    .busy        (busy),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ROM contents used by the tests
  always_comb begin
    case (rom_addr)
      12'h01F: rom_dout = 16'hBEEF;
      12'h000: rom_dout = 16'h7A30;
      default: rom_dout = 16'hFFFF;
    endcase
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  bit lat_pending = 0;
  int trig_cyc = 0;
  int last_send_cyc = 0;
  bit have_last = 0;
  logic tx_send_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop expected byte on every tx_send, check latency and spacing
  always @(negedge clk) begin
    if (tx_send) begin
      logic [7:0] e;
      check("tx_send_single", {31'd0, tx_send_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_send: got %0h expected none (cycle %0d)", tx_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("tx_data", {24'd0, tx_data}, {24'd0, e});
      end
      if (lat_pending) begin
        check("first_latency", cyc - trig_cyc, 2);
        lat_pending = 0;
      end else if (have_last) begin
        check("tx_spacing", cyc - last_send_cyc, EXP_GAP);
      end
      last_send_cyc = cyc;
      have_last = 1;
    end
    tx_send_prev = tx_send;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    trig_cyc = cyc;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic expect_reply(input string s, input bit crlf);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    if (crlf) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    lat_pending = 1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("busy_rise", {31'd0, busy}, 32'd1);
    t = 0;
    while (busy && t < 8 * EXP_GAP) begin
      @(negedge clk);
      t++;
    end
    check("busy_timeout", {31'd0, busy}, 32'd0);
    check("busy_fall", cyc - last_send_cyc, EXP_GAP);
    check("reply_complete", exp_q.size(), 0);
  endtask

  task automatic wait_exp_size(input int n);
    int t = 0;
    while (exp_q.size() > n && t < 8 * EXP_GAP) begin
      @(negedge clk);
      t++;
    end
    check("reply_progress", exp_q.size(), n);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_send", {31'd0, tx_send}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'h00);
    check("rst_rom_addr", {20'd0, rom_addr}, 32'h000);
    check("rst_led", {28'd0, led}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    #2 rst_n = 1'b1;

    // LED toggles, no reply
    send_byte("1"); check("led_t2a", {28'd0, led}, 32'b0001);
    send_byte("3"); check("led_t2b", {28'd0, led}, 32'b0101);
    send_byte("1"); check("led_t2c", {28'd0, led}, 32'b0100);
    repeat (20) @(posedge clk);

    // ROM read of 0x01F with a dropped '2' while busy
    expect_reply("BEEF", 1);
    send_str("R01f");
    check("addr_01f", {20'd0, rom_addr}, 32'h01F);
    send_byte(8'h0D);
    wait_exp_size(4);
    send_byte("2");
    check("led_busy_drop", {28'd0, led}, 32'b0100);
    wait_idle();
    check("led_after_reply", {28'd0, led}, 32'b0100);
    send_byte("2");
    check("led_t5", {28'd0, led}, 32'b0110);

    // Bad hex digit
    do_reset();
    expect_reply("?", 1);
    send_str("R1G");
    check("addr_001", {20'd0, rom_addr}, 32'h001);
    wait_idle();
    check("led_t3", {28'd0, led}, 32'b0000);

    // Short address terminated by CR
    expect_reply("?", 1);
    send_str("R12");
    send_byte(8'h0D);
    wait_idle();
    check("addr_112", {20'd0, rom_addr}, 32'h112);

    // 'R' inside the address is not hex
    expect_reply("?", 1);
    send_str("RR");
    wait_idle();

    // Non-CR after three digits
    expect_reply("?", 1);
    send_str("rAbc5");
    check("addr_abc", {20'd0, rom_addr}, 32'hABC);
    wait_idle();

    // Reset in the middle of the third reply byte
    send_byte("4");
    check("led_t6", {28'd0, led}, 32'b1000);
    expect_reply("BEE", 0);
    send_str("R01f");
    send_byte(8'h0D);
    wait_exp_size(0);
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_tx_send", {31'd0, tx_send}, 32'd0);
    check("abort_tx_data", {24'd0, tx_data}, 32'h00);
    check("abort_rom_addr", {20'd0, rom_addr}, 32'h000);
    check("abort_led", {28'd0, led}, 32'h0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2 * EXP_GAP) @(posedge clk);
    check("quiet_after_abort", {31'd0, busy}, 32'd0);

    expect_reply("7A30", 1);
    send_str("R000");
    send_byte(8'h0D);
    wait_idle();
    check("addr_000", {20'd0, rom_addr}, 32'h000);

    repeat (10) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rom_cmd.md
Name: uart_rom_cmd

Overview:
- Command stage that sits directly downstream of a UART receiver and directly upstream of the same UART's transmitter.
- Consumes received bytes (rx_valid/rx_data) and parses ASCII commands.
- Reads the 16-bit-wide, 4096-deep combinational ROM and answers in ASCII hex through tx_send/tx_data.
- Also owns the four user LEDs, toggled by single-character commands '1'..'4'.

Parameters:
- BIT_WIDTH, 11, UART frame length in bits; used for transmit pacing.
- BAUD_RATE, 230400, line rate in bit/s.
- CLOCK_FREQ_HZ, 100000000, clk frequency in Hz.
- ADDR_W, 12, ROM address width; fixed at 3 hex digits.
- DATA_W, 16, ROM data width; fixed at 4 hex digits.

Ports:
- clk, in, 1: single system clock; everything is on its rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- rx_valid, in, 1: one-cycle pulse from the UART receiver; rx_data is valid in that cycle.
- rx_data, in, 8: received byte.
- tx_send, out, 1: one-cycle pulse requesting the UART transmitter to send tx_data.
- tx_data, out, 8: byte to transmit; held stable until the next tx_send.
- rom_addr, out, ADDR_W: ROM address (registered).
- rom_dout, in, DATA_W: ROM read data, combinational from rom_addr.
- led, out, 4: LED state.
- busy, out, 1: high while a reply is being transmitted; rx bytes are dropped while high.

Behaviour:
- Reset (async assert, sync release): state=IDLE; tx_send=0, tx_data=0x00, rom_addr=0, led=0, busy=0, digit count=0.
- TX_GAP = (CLOCK_FREQ_HZ/BAUD_RATE)*BIT_WIDTH, using integer division. Defaults give 434*11 = 4774 cycles.
- The UART exposes no ready signal, so consecutive tx_send pulses are spaced exactly TX_GAP cycles apart.
- States:
  - IDLE:
    - '1'..'4' (0x31..0x34) toggles led[0..3].
    - 'R'/'r' clears the digit count and goes to ADDR.
    - Any other byte is ignored.
  - ADDR:
    - A hex digit (0-9, A-F, a-f) shifts into rom_addr from the LSB end (rom_addr <= {rom_addr[7:0], nibble}) and increments the count.
    - When the count reaches 3, go to WAIT_CR.
    - A non-hex byte, including CR with fewer than 3 digits, goes to ERR.
  - WAIT_CR:
    - 0x0D goes to ROM.
    - Any other byte goes to ERR.
  - ROM: one cycle; capture rom_dout into the reply register, then go to TX.
  - ERR: load reply '?', CR, LF (3 bytes), then go to TX.
  - TX:
    - busy=1 throughout.
    - Emit the reply bytes in order.
    - Read reply: 4 uppercase hex digits of the data, MS nibble first, then 0x0D, 0x0A (6 bytes).
    - After the last send, wait a full TX_GAP, then go to IDLE with busy=0.
- Latency: if CR is sampled at edge k, the first tx_send is high in the cycle following edge k+2.
- ERR latency: the first '?' send follows the offending byte by 2 cycles.
- While busy, rx_valid is ignored completely: no LED toggles and no parse.
- rom_addr holds its last value after the command completes.
- Partial commands never time out.
- 'R' received inside ADDR is non-hex and causes ERR.
- LED toggles happen only in IDLE; '1' inside ADDR is a hex digit.
- Reset asserted mid-TX aborts the reply immediately. No partial byte is re-sent after release.
- tx_send is never high for more than one consecutive cycle.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - state enum (IDLE, ADDR, WAIT_CR, ROM, ERR, TX);
  - ASCII constants (CR, LF, '?', 'R', 'r', '1'..'4');
  - function tx_gap(clock_freq_hz, baud_rate, bit_width).
- One sub-module, hex_ascii_codec, purely combinational:
  - nibble to uppercase ASCII;
  - ASCII to nibble plus an is_hex flag.
- The top level instantiates uart_rom_cmd between the UART's valid/rx_data and send/tx_data ports.

Test Plan:
1. Reset, then rx "R", "0", "1", "f", 0x0D with rom[0x01F]=0xBEEF:
   - rom_addr=0x01F;
   - six tx_send pulses carrying 'B','E','E','F',0x0D,0x0A, spaced 4774 cycles apart;
   - busy falls 4774 cycles after the last pulse.
2. rx "1", "3", "1":
   - led goes 0001, then 0101, then 0100;
   - no tx_send.
3. rx "R", "1", "G":
   - '?', 0x0D, 0x0A are sent;
   - rom_addr=0x001;
   - led unchanged.
4. rx "R", "1", "2", 0x0D (short address):
   - '?', CR, LF are sent.
5. rx "2" while busy during test 1's reply:
   - led unchanged;
   - the reply is intact;
   - after busy=0, "2" toggles led[1].
6. Pulse rst_n low during the 3rd reply byte:
   - all outputs return to 0 asynchronously;
   - no further tx_send;
   - the next "R", "0", "0", "0", CR works normally.
